// File: rtl/conv3x3_stream.sv
// Streaming 3x3 valid-mode convolution with line buffers,
// signed kernel, shift/saturate and out_ready backpressure.
module conv3x3_stream #(
  parameter int PIX_W  = 8,
  parameter int COEF_W = 12,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int SHIFT  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [PIX_W-1:0]      in_pixel,
  input  logic [9*COEF_W-1:0]   kernel,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PIX_W-1:0]      out_pixel,
  output logic                  out_last,
  output logic                  frame_done
);

  localparam int AW = PIX_W + COEF_W + 5;
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_TWO = CW'(2);
  localparam logic [RW-1:0] ROW_TWO = RW'(2);
  localparam logic signed [AW-1:0] PMAX = AW'((1 << PIX_W) - 1);

  logic [CW-1:0]        col;
  logic [RW-1:0]        row;
  logic [9*COEF_W-1:0]  kreg;
  logic [PIX_W-1:0]     lb1 [IMG_W];
  logic [PIX_W-1:0]     lb2 [IMG_W];
  logic [PIX_W-1:0]     t0, t1, m0, m1, b0, b1;
  logic [PIX_W-1:0]     tap [9];
  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] s1_acc;
  logic signed [AW-1:0] res;
  logic                 s1_valid, s1_last;
  logic [PIX_W-1:0]     sat;
  logic                 advance, accept, win, last;

  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance;
  assign accept   = in_valid & advance;
  assign win      = accept & (row >= ROW_TWO) & (col >= COL_TWO);
  assign last     = (row == ROW_MAX) & (col == COL_MAX);

  // Window columns c-2, c-1 live in t/m/b regs; column c comes
  // straight from the line buffers and the incoming pixel.
  always_comb begin
    tap[0] = t0;
    tap[1] = t1;
    tap[2] = lb2[col];
    tap[3] = m0;
    tap[4] = m1;
    tap[5] = lb1[col];
    tap[6] = b0;
    tap[7] = b1;
    tap[8] = in_pixel;
  end

  always_comb begin
    acc = '0;
    for (int i = 0; i < 9; i++) begin
      acc = acc + AW'($signed(kreg[i*COEF_W +: COEF_W]))
                * $signed(AW'({1'b0, tap[i]}));
    end
  end

  always_comb begin
    res = s1_acc >>> SHIFT;
    sat = res[PIX_W-1:0];
    if (res[AW-1])
      sat = '0;
    else if (res > PMAX)
      sat = '1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col  <= '0;
      row  <= '0;
      kreg <= '0;
    end else if (accept) begin
      if (row == '0 && col == '0)
        kreg <= kernel;
      if (col == COL_MAX) begin
        col <= '0;
        row <= (row == ROW_MAX) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      lb2[col] <= lb1[col];
      lb1[col] <= in_pixel;
      t0 <= t1;
      t1 <= lb2[col];
      m0 <= m1;
      m1 <= lb1[col];
      b0 <= b1;
      b1 <= in_pixel;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid   <= 1'b0;
      s1_last    <= 1'b0;
      s1_acc     <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      out_pixel  <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= out_valid & out_ready & out_last;
      if (advance) begin
        s1_valid  <= win;
        s1_last   <= win & last;
        s1_acc    <= acc;
        out_valid <= s1_valid;
        out_last  <= s1_last;
        if (s1_valid)
          out_pixel <= sat;
      end
    end
  end

endmodule
